// File: rtl/led_sequencer.sv
// led_sequencer: debounced two-button colour sequencer for the board RGB LED.
// Button 0 steps the colour, button 1 toggles auto-advance, and the active
// colour is gated by a shared PWM dimmer before reaching the LED pins.
//
// state   | meaning
// --------+-----------------------------------------------
// S_OFF   | dark; left only by an advance press
// S_RED   | red channel driven
// S_GREEN | green channel driven
// S_BLUE  | blue channel driven
// S_WHITE | all three channels driven; advances back to red
module led_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DWELL_CYCLES    = 12000000,
  parameter int unsigned PWM_BITS        = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push_button0,
  input  logic                push_button1,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                led_red,
  output logic                led_green,
  output logic                led_blue,
  output logic [2:0]          state,
  output logic                running
);

  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_RED   = 3'd1,
    S_GREEN = 3'd2,
    S_BLUE  = 3'd3,
    S_WHITE = 3'd4
  } state_e;

  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          deb_q, deb_prev_q;
  logic [DEB_W-1:0]    deb_cnt_q [2];
  logic [1:0]          press;

  state_e              state_q, state_d;
  logic                running_q, running_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                dwell_hit;
  logic                advance;

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] duty_q;
  logic                pwm_on;
  logic [2:0]          mask;
  logic [2:0]          led_q;

  // Two-flop synchroniser for both raw button levels (bit 0 = advance, bit 1 = run).
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {push_button1, push_button0};
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has disagreed with deb for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (deb_cnt_q[i] == DEB_LAST) begin
            deb_q[i]     <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  // Sequencer state, run flag and dwell timer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_OFF;
      running_q <= 1'b0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      dwell_q   <= dwell_d;
    end
  end

  // Next colour, run toggle and dwell count; a press coinciding with expiry is one step.
  always_comb begin
    state_d   = state_q;
    running_d = running_q;
    dwell_d   = dwell_q;
    dwell_hit = running_q && (state_q != S_OFF) && (dwell_q == DWELL_LAST);
    advance   = press[0] || dwell_hit;

    case (state_q)
      S_OFF:   if (advance) state_d = S_RED;
      S_RED:   if (advance) state_d = S_GREEN;
      S_GREEN: if (advance) state_d = S_BLUE;
      S_BLUE:  if (advance) state_d = S_WHITE;
      S_WHITE: if (advance) state_d = S_RED;
      default: state_d = S_OFF;
    endcase

    if (press[1]) running_d = ~running_q;

    if (advance || press[1] || !running_q || (state_q == S_OFF)) dwell_d = '0;
    else                                                         dwell_d = dwell_q + DWELL_W'(1);
  end

  // Free-running PWM counter; duty is only refreshed at the period boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      if (pwm_cnt_q == '1) duty_q <= brightness;
    end
  end

  assign pwm_on = (pwm_cnt_q < duty_q);

  // Colour mask {red, green, blue} for the current state.
  always_comb begin
    mask = 3'b000;
    case (state_q)
      S_RED:   mask = 3'b100;
      S_GREEN: mask = 3'b010;
      S_BLUE:  mask = 3'b001;
      S_WHITE: mask = 3'b111;
      default: mask = 3'b000;
    endcase
  end

  // Registered LED drive so the pins never see combinational glitches.
  always_ff @(posedge clock) begin
    if (reset) led_q <= '0;
    else       led_q <= mask & {3{pwm_on}};
  end

  assign led_red   = led_q[2];
  assign led_green = led_q[1];
  assign led_blue  = led_q[0];
  assign state     = state_q;
  assign running   = running_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with DEBOUNCE_CYCLES=4, DWELL_CYCLES=16.
module tb_led_sequencer;

  logic       clock;
  logic       reset;
  logic       push_button0;
  logic       push_button1;
  logic [7:0] brightness;
  logic       led_red, led_green, led_blue;
  logic [2:0] state;
  logic       running;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  led_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .DWELL_CYCLES(16),
    .PWM_BITS(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .push_button0(push_button0),
    .push_button1(push_button1),
    .brightness(brightness),
    .led_red(led_red),
    .led_green(led_green),
    .led_blue(led_blue),
    .state(state),
    .running(running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference copy of the PWM counter: edges since the last reset edge.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int         b0_len;
    int         b1_len;
    logic [2:0] exp_state;
    logic       exp_running;
    logic [2:0] exp_mask;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic count_leds(input int n, output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < n; i++) begin
      r += int'(led_red);
      g += int'(led_green);
      b += int'(led_blue);
      step(1);
    end
  endtask

  // One PWM period aligned so the first sample reflects pwm_cnt=0.
  task automatic count_period(input int change_at, input logic [7:0] new_bri, output int r);
    r = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == change_at) brightness = new_bri;
      r += int'(led_red);
      step(1);
    end
  endtask

  task automatic align_to_period;
    step(2);
    for (int i = 0; i < 300 && (cyc % 256) != 1; i++) step(1);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, g, b, mx;

    vecs[0] = '{3, 0, 3'd0, 1'b0, 3'b000};
    vecs[1] = '{0, 3, 3'd0, 1'b0, 3'b000};
    vecs[2] = '{4, 0, 3'd1, 1'b0, 3'b100};
    vecs[3] = '{6, 0, 3'd2, 1'b0, 3'b010};
    vecs[4] = '{6, 0, 3'd3, 1'b0, 3'b001};
    vecs[5] = '{6, 0, 3'd4, 1'b0, 3'b111};
    vecs[6] = '{6, 0, 3'd1, 1'b0, 3'b100};

    reset        = 1'b1;
    push_button0 = 1'b0;
    push_button1 = 1'b0;
    brightness   = 8'd255;
    @(negedge clock);
    step(3);
    reset = 1'b0;
    check("reset state", int'(state), 0);
    check("reset running", int'(running), 0);
    check("reset leds", int'({led_red, led_green, led_blue}), 0);

    // Exact latency of an accepted press: state at k+6, first PWM period dark.
    push_button0 = 1'b1;
    step(6);
    check("latency state before k+6", int'(state), 0);
    step(1);
    check("latency state at k+6", int'(state), 1);
    step(1);
    check("first period dark", int'(led_red), 0);
    step(2);
    push_button0 = 1'b0;
    step(300);
    count_leds(256, r, g, b);
    check("red duty 255", r, 255);
    check("green dark", g, 0);
    check("blue dark", b, 0);

    // Table: glitches, exact-threshold press, then a full colour cycle.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      mx = (vecs[i].b0_len > vecs[i].b1_len) ? vecs[i].b0_len : vecs[i].b1_len;
      for (int j = 0; j < mx; j++) begin
        push_button0 = (j < vecs[i].b0_len);
        push_button1 = (j < vecs[i].b1_len);
        step(1);
      end
      push_button0 = 1'b0;
      push_button1 = 1'b0;
      step(12);
      check($sformatf("row%0d state", i), int'(state), int'(vecs[i].exp_state));
      check($sformatf("row%0d running", i), int'(running), int'(vecs[i].exp_running));
      count_leds(256, r, g, b);
      check($sformatf("row%0d red", i), r, vecs[i].exp_mask[2] ? 255 : 0);
      check($sformatf("row%0d green", i), g, vecs[i].exp_mask[1] ? 255 : 0);
      check($sformatf("row%0d blue", i), b, vecs[i].exp_mask[0] ? 255 : 0);
    end

    // Run mode from RED: one step every 16 edges after running rises.
    push_button1 = 1'b1;
    step(6);
    check("run before k+6", int'(running), 0);
    push_button1 = 1'b0;
    step(1);
    check("run at k+6", int'(running), 1);
    for (int s = 0; s < 4; s++) begin
      step(15);
      check($sformatf("dwell hold %0d", s), int'(state), (s == 0) ? 1 : s + 1);
      step(1);
      check($sformatf("dwell step %0d", s), int'(state), (s == 3) ? 1 : s + 2);
    end
    push_button1 = 1'b1;
    step(6);
    push_button1 = 1'b0;
    step(1);
    check("pause running", int'(running), 0);
    step(40);
    check("pause frozen", int'(state), 1);

    // running=1 in OFF stays in OFF; press0 leaves it and the dwell takes over.
    do_reset();
    push_button1 = 1'b1;
    step(6);
    push_button1 = 1'b0;
    step(1);
    check("off run set", int'(running), 1);
    step(40);
    check("off stays off", int'(state), 0);
    push_button0 = 1'b1;
    step(6);
    check("off before press", int'(state), 0);
    push_button0 = 1'b0;
    step(1);
    check("off to red", int'(state), 1);
    step(15);
    check("red dwell hold", int'(state), 1);
    step(1);
    check("red dwell step", int'(state), 2);

    // press0 pulse lands exactly on the dwell expiry edge: one step only.
    step(9);
    push_button0 = 1'b1;
    step(6);
    check("collide before", int'(state), 2);
    push_button0 = 1'b0;
    step(1);
    check("collide single step", int'(state), 3);
    step(15);
    check("collide hold", int'(state), 3);
    step(1);
    check("collide next dwell", int'(state), 4);

    // Both buttons in one cycle: one step and the run flag toggles.
    push_button0 = 1'b1;
    push_button1 = 1'b1;
    step(6);
    check("both before state", int'(state), 4);
    push_button0 = 1'b0;
    push_button1 = 1'b0;
    step(1);
    check("both state", int'(state), 1);
    check("both running", int'(running), 0);
    step(30);
    check("both frozen", int'(state), 1);

    // PWM: brightness 64, changed to 0 mid-period takes effect next period.
    brightness = 8'd64;
    align_to_period();
    count_period(-1, 8'd64, r);
    check("duty 64", r, 64);
    count_period(100, 8'd0, r);
    check("duty change deferred", r, 64);
    count_period(-1, 8'd0, r);
    check("duty 0 dark", r, 0);

    // Reset mid-period while lit.
    brightness = 8'd255;
    step(260);
    for (int i = 0; i < 300 && (cyc % 256) != 100; i++) step(1);
    check("lit before reset", int'(led_red), 1);
    reset = 1'b1;
    step(1);
    check("mid reset leds", int'({led_red, led_green, led_blue}), 0);
    check("mid reset state", int'(state), 0);
    check("mid reset running", int'(running), 0);
    reset = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Controller that owns the board RGB LED. It takes the two active-high (already inverted) push-button levels, debounces them, and steps a colour state machine. Steps come from button presses or an auto-advance dwell timer. The active colour is driven through a shared PWM dimmer. It sits between the board wrapper's button outputs and its active-high LED inputs, and replaces ad-hoc per-sample LED logic.

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles needed to accept a new button level (≥2; benches use 4).
- DWELL_CYCLES, 12000000: cycles per colour in run mode (≥2; benches use 16).
- PWM_BITS, 8: width of the PWM counter and brightness.

Ports:
- clock  in  1: single clock; all logic on its rising edge.
- reset  in  1: synchronous, active-high.
- push_button0  in  1: advance request, active-high, asynchronous to clock.
- push_button1  in  1: run/pause toggle, active-high, asynchronous to clock.
- brightness  in  PWM_BITS: PWM duty.
- led_red, led_green, led_blue  out  1 each: active-high, registered.
- state  out  3: current colour state.
- running  out  1: auto-advance enabled.

## Operation
- Synchroniser: per button, two flops, sync1 then sync2.
- Debounce: per button, a counter with width for DEBOUNCE_CYCLES.
  - If sync2 ≠ deb, the counter increments.
  - If the counter equals DEBOUNCE_CYCLES-1 and there is still a mismatch, deb takes sync2 and the counter clears.
  - If sync2 = deb, the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Press pulse: press0 and press1 equal deb & ~deb_q, one cycle per accepted rising level. Releases produce nothing.
- States: OFF=0, RED=1, GREEN=2, BLUE=3, WHITE=4.
  - Advance order: OFF→RED→GREEN→BLUE→WHITE→RED.
  - OFF is re-entered only by reset.
  - Encodings 5–7 are unreachable; if ever present, the next state is OFF.
- Advance event: press0 OR (dwell expiry). Both in the same cycle give a single step, never two.
- Run flag: press1 toggles running.
- press0 and press1 in the same cycle: both take effect in that cycle.
- Dwell counter:
  - Counts only when running=1 and state≠OFF.
  - On reaching DWELL_CYCLES-1 it signals expiry and clears.
  - Clears on any advance, on pause, and whenever state=OFF.
  - OFF is left only via press0; running=1 alone never leaves OFF.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps to 0.
  - duty_q loads brightness when pwm_cnt = all-ones, so changes take effect only at period boundaries.
  - pwm_on = (pwm_cnt < duty_q).
  - brightness=0 gives always dark; all-ones gives lit 2^PWM_BITS−1 of 2^PWM_BITS cycles.
- Colour mask: OFF=000, RED=100, GREEN=010, BLUE=001, WHITE=111.
- LED outputs: led_x registers (mask_x & pwm_on).

## Timing
- Reset values: led_red=led_green=led_blue=0, state=OFF, running=0. All internal registers are 0: sync, deb, counters, pwm_cnt, duty_q.
- First PWM period after reset is dark (duty_q=0). duty_q loads at pwm_cnt=2^PWM_BITS−1.
- Reset asserted mid-operation overrides everything in that cycle. Any press in flight is lost.
- Raw level first sampled at edge k:
  - deb changes after edge k+1+DEBOUNCE_CYCLES.
  - state/running update after edge k+2+DEBOUNCE_CYCLES.
  - LEDs reflect the new state after edge k+3+DEBOUNCE_CYCLES.
- Dwell: in run mode, an advance occurs every DWELL_CYCLES cycles exactly, measured from entering the colour or from the last advance.
- PWM period is 2^PWM_BITS cycles. The LED lags pwm_cnt by one cycle.

## Test plan
- Reset and brightness=255, DEBOUNCE_CYCLES=4: state=0, running=0, all LEDs 0. Hold button0 high 10 cycles, then low → state 1 at edge k+6, led_red toggles with 255/256 duty, green/blue 0.
- Glitch rejection: pulse button0 high for 3 cycles (DEBOUNCE_CYCLES=4) → state stays 0, no LED activity.
- Sequencing: five clean presses from OFF → states 1,2,3,4,1. WHITE drives all three LEDs identically.
- Run mode (DWELL_CYCLES=16): press0 (RED), press1 → running=1. State advances every 16 cycles: 2,3,4,1. A second press1 → running=0, state frozen. Confirm running=1 in OFF never leaves OFF.
- Collision: align a press0 pulse with dwell expiry → exactly one step. press0 and press1 in the same cycle → one step and running toggles.
- PWM: brightness=64 → per 256-cycle period exactly 64 lit cycles. Change brightness to 0 mid-period → the current period completes at 64, then stays dark. Assert reset mid-period → LEDs 0 next cycle, state=0.
